// File: rtl/nes_controller_reader_pkg.sv
// Shared types and constants for the NES pad reader.
package nes_controller_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } nes_state_t;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam int DEF_LATCH_CYCLES = 300;
   localparam int DEF_HALF_CYCLES  = 150;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nes_controller_reader_data_sync.sv
// Two-flop synchroniser for the asynchronous pad data line.
module nes_data_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Reset to 1 so the idle (pulled-high) line reads as released.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nes_controller_reader.sv
// Serial reader for a 4021-based NES pad.
// Optional NES_DEBOUNCE_EN: update buttons only when two reads agree.
module nes_controller_reader
   import nes_controller_reader_pkg::*;
#(
   parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
   parameter int HALF_CYCLES  = DEF_HALF_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_clk,
   output logic [7:0] buttons,
   output logic       valid,
   output logic       busy
);

   localparam int CW = $clog2(max2(LATCH_CYCLES, HALF_CYCLES) + 1);
   localparam logic [CW-1:0] LATCH_LD = CW'(LATCH_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LD  = CW'(HALF_CYCLES - 1);

   nes_state_t    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic          data_sync;
`ifdef NES_DEBOUNCE_EN
   logic [7:0]    prev;
`endif

   nes_data_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (nes_data),
      .q     (data_sync)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         nes_latch <= 1'b0;
         nes_clk   <= 1'b0;
         buttons   <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
`ifdef NES_DEBOUNCE_EN
         prev      <= '0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_LATCH;
                  cnt       <= LATCH_LD;
                  nes_latch <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_LATCH: begin
               if (cnt == '0) begin
                  state     <= ST_LOW;
                  cnt       <= HALF_LD;
                  idx       <= '0;
                  nes_latch <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_LOW: begin
               if (cnt == '0) begin
                  shift[idx] <= ~data_sync;
                  state      <= ST_HIGH;
                  cnt        <= HALF_LD;
                  nes_clk    <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HIGH: begin
               if (cnt == '0) begin
                  nes_clk <= 1'b0;
                  if (idx == 3'd7) begin
                     // Outputs for DONE are registered on entry.
                     state <= ST_DONE;
                     valid <= 1'b1;
`ifdef NES_DEBOUNCE_EN
                     prev  <= shift;
                     if (shift == prev)
                        buttons <= shift;
`else
                     buttons <= shift;
`endif
                  end else begin
                     state <= ST_LOW;
                     cnt   <= HALF_LD;
                     idx   <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               nes_latch <= 1'b0;
               nes_clk   <= 1'b0;
               valid     <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a 4021 pad model.
module tb_nes_controller_reader;

   localparam int LC = 6;
   localparam int HC = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       nes_data;
   logic       nes_latch;
   logic       nes_clk;
   logic [7:0] buttons;
   logic       valid;
   logic       busy;

   logic [7:0] pad = 8'h00;
   logic       pad_stuck = 1'b0;
   logic [7:0] sr = 8'h00;

   int n_tests = 0;
   int n_fail  = 0;
   int vcount  = 0;
   int crises  = 0;

   always #5 clk = ~clk;

   nes_controller_reader #(
      .LATCH_CYCLES (LC),
      .HALF_CYCLES  (HC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .nes_data  (nes_data),
      .nes_latch (nes_latch),
      .nes_clk   (nes_clk),
      .buttons   (buttons),
      .valid     (valid),
      .busy      (busy)
   );

   // 4021: parallel load while latch high, shift on rising clock.
   always @(posedge nes_clk or posedge nes_latch) begin
      if (nes_latch) sr <= pad;
      else           sr <= {1'b0, sr[7:1]};
   end
   assign nes_data = pad_stuck ? 1'b1 : ~sr[0];

   always @(negedge clk) if (valid) vcount++;
   always @(posedge nes_clk) crises++;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
      end
   endtask

   // mode 0: plain read, 1: extra starts mid-read and in DONE,
   // 2: one-cycle reset during the 4th HIGH phase.
   task automatic read_pad(input logic [7:0] p, input int mode,
                           output int vk, output int bk,
                           output int lat_n, output int lat_first,
                           output int hi_n);
      vk = -1; bk = -1; lat_n = 0; lat_first = -1; hi_n = 0;
      pad = p;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         if (k > 1) @(negedge clk);
         if (nes_latch) begin
            lat_n++;
            if (lat_first < 0) lat_first = k;
         end
         if (nes_clk) hi_n++;
         if (valid && vk < 0) vk = k;
         if (!busy && bk < 0) bk = k;
         if (mode == 1) begin
            if (k == 30 || k == 71) start = 1'b1;
            if (k == 31 || k == 72) start = 1'b0;
         end
         if (mode == 2) begin
            if (k == 36) reset = 1'b1;
            if (k == 37) begin
               reset = 1'b0;
               check("rst_latch",   nes_latch, 0);
               check("rst_clk",     nes_clk,   0);
               check("rst_busy",    busy,      0);
               check("rst_buttons", buttons,   0);
            end
         end
      end
   endtask

   int vk, bk, ln, lf, hn, v0, c0;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_latch",   nes_latch, 0);
      check("reset_clk",     nes_clk,   0);
      check("reset_buttons", buttons,   0);
      check("reset_valid",   valid,     0);
      check("reset_busy",    busy,      0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // A + Up, full timing check.
      v0 = vcount; c0 = crises;
      read_pad(8'h11, 0, vk, bk, ln, lf, hn);
      check("t1_latch_first", lf, 1);
      check("t1_latch_len",   ln, LC);
      check("t1_clk_pulses",  crises - c0, 8);
      check("t1_clk_high",    hn, 8 * HC);
      check("t1_valid_at",    vk, 71);
      check("t1_busy_low",    bk, 72);
      check("t1_buttons",     buttons, 8'h11);
      check("t1_nvalid",      vcount - v0, 1);

      // Disconnected pad.
      pad_stuck = 1'b1;
      v0 = vcount;
      read_pad(8'hFF, 0, vk, bk, ln, lf, hn);
      pad_stuck = 1'b0;
      check("t2_buttons", buttons, 8'h00);
      check("t2_nvalid",  vcount - v0, 1);

      // Extra starts mid-read and in DONE are ignored.
      v0 = vcount;
      read_pad(8'h80, 1, vk, bk, ln, lf, hn);
      check("t3_valid_at", vk, 71);
      check("t3_buttons",  buttons, 8'h80);
      check("t3_nvalid",   vcount - v0, 1);
      check("t3_idle",     busy, 0);
      read_pad(8'h02, 0, vk, bk, ln, lf, hn);
      check("t3_next_valid", vk, 71);
      check("t3_buttons2",   buttons, 8'h02);
      check("t3_nvalid2",    vcount - v0, 2);

      // Reset mid-read aborts with no valid.
      v0 = vcount;
      read_pad(8'h55, 2, vk, bk, ln, lf, hn);
      check("t4_no_valid", vk, -1);
      check("t4_nvalid",   vcount - v0, 0);
      check("t4_buttons",  buttons, 8'h00);

      // Debounce sequence.
      read_pad(8'h04, 0, vk, bk, ln, lf, hn);
`ifdef NES_DEBOUNCE_EN
      check("t5_rd1", buttons, 8'h00);
`else
      check("t5_rd1", buttons, 8'h04);
`endif
      read_pad(8'h04, 0, vk, bk, ln, lf, hn);
      check("t5_rd2", buttons, 8'h04);
      read_pad(8'h08, 0, vk, bk, ln, lf, hn);
`ifdef NES_DEBOUNCE_EN
      check("t5_rd3", buttons, 8'h04);
`else
      check("t5_rd3", buttons, 8'h08);
`endif
      check("t5_valid_at", vk, 71);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
